// File: rtl/mc_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes, FSM states, ALU ops, pc mux selects.
package mc_sequencer_pkg;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4,
    StErr = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    ClsR,
    ClsIAlu,
    ClsLui,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsIllegal
  } inst_cls_e;

  localparam logic [3:0] AlucAdd = 4'b0000;
  localparam logic [3:0] AlucSub = 4'b1000;
  localparam logic [3:0] AlucSra = 4'b1101;

  localparam logic [1:0] PcsP4     = 2'b00;
  localparam logic [1:0] PcsBranch = 2'b01;
  localparam logic [1:0] PcsJalr   = 2'b10;
  localparam logic [1:0] PcsJal    = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: instruction class, illegal flag and ALU operation.
module mc_decode
  import mc_sequencer_pkg::*;
(
  input  logic [31:0] inst_i,
  output inst_cls_e   cls_o,
  output logic        illegal_o,
  output logic [3:0]  aluc_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];

  always_comb begin
    cls_o = ClsIllegal;
    case (opcode)
      OpcOp:     cls_o = ClsR;
      OpcOpImm:  cls_o = ClsIAlu;
      OpcLui:    cls_o = ClsLui;
      OpcLoad:   cls_o = ClsLoad;
      OpcStore:  cls_o = ClsStore;
      // Only beq/bne are supported; other branch conditions trap.
      OpcBranch: cls_o = (funct3[2:1] == 2'b00) ? ClsBranch : ClsIllegal;
      OpcJal:    cls_o = ClsJal;
      OpcJalr:   cls_o = ClsJalr;
      default:   cls_o = ClsIllegal;
    endcase
  end

  always_comb begin
    aluc_o = AlucAdd;
    case (cls_o)
      ClsR:      aluc_o = {inst_i[30], funct3};
      ClsIAlu:   aluc_o = (funct3 == 3'b101 && inst_i[30]) ? AlucSra : {1'b0, funct3};
      ClsBranch: aluc_o = AlucSub;
      default:   aluc_o = AlucAdd;
    endcase
  end

  assign illegal_o = (cls_o == ClsIllegal);

  logic unused_inst;
  assign unused_inst = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control FSM: IF/ID/EX/MEM/WB sequencing with a sticky error state.
module mc_sequencer
  import mc_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        iord_o,
  output logic        wmem_o,
  output logic        ir_we_o,
  output logic        pc_we_o,
  output logic [1:0]  pcsource_o,
  output logic        wreg_o,
  output logic        m2reg_o,
  output logic        link_o,
  output logic        aluimm_o,
  output logic [3:0]  aluc_o,
  output logic        illegal_o,
  output logic [2:0]  state_o
);

  state_e    state_q, state_d;
  inst_cls_e cls;
  logic      dec_illegal;
  logic [3:0] dec_aluc;
  logic      br_taken;

  mc_decode u_decode (
    .inst_i    (inst_i),
    .cls_o     (cls),
    .illegal_o (dec_illegal),
    .aluc_o    (dec_aluc)
  );

  assign br_taken = ((inst_i[14:12] == 3'b000) && zero_i) ||
                    ((inst_i[14:12] == 3'b001) && !zero_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIf;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    iord_o     = 1'b0;
    wmem_o     = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pcsource_o = PcsP4;
    wreg_o     = 1'b0;
    m2reg_o    = 1'b0;
    link_o     = 1'b0;
    aluimm_o   = 1'b0;
    aluc_o     = AlucAdd;
    illegal_o  = 1'b0;

    unique case (state_q)
      StIf: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          // Keep the instruction register quiet while reset is held.
          ir_we_o = !rst_i;
          state_d = StId;
        end
      end
      StId: begin
        state_d = dec_illegal ? StErr : StEx;
      end
      StEx: begin
        aluimm_o = (cls != ClsR) && (cls != ClsBranch);
        aluc_o   = dec_aluc;
        case (cls)
          ClsBranch: begin
            pc_we_o    = 1'b1;
            pcsource_o = br_taken ? PcsBranch : PcsP4;
            state_d    = StIf;
          end
          ClsLoad, ClsStore: state_d = StMem;
          default:           state_d = StWb;
        endcase
      end
      StMem: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        wmem_o    = (cls == ClsStore);
        aluc_o    = dec_aluc;
        if (mem_ready_i) begin
          if (cls == ClsStore) begin
            pc_we_o = 1'b1;
            state_d = StIf;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        wreg_o  = 1'b1;
        pc_we_o = 1'b1;
        m2reg_o = (cls == ClsLoad);
        link_o  = (cls == ClsJal) || (cls == ClsJalr);
        aluc_o  = dec_aluc;
        if (cls == ClsJal) begin
          pcsource_o = PcsJal;
        end else if (cls == ClsJalr) begin
          pcsource_o = PcsJalr;
        end
        state_d = StIf;
      end
      StErr: begin
        illegal_o = 1'b1;
      end
      default: begin
        state_d = StErr;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized and directed bench for mc_sequencer against a per-instruction phase-list model.
module tb_mc_sequencer;

  localparam int CR = 0, CI = 1, CU = 2, CL = 3, CS = 4, CB = 5, CJ = 6, CJR = 7, CX = 8;
  localparam int PIF = 0, PID = 1, PEX = 2, PMEM = 3, PWB = 4, PERR = 7;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] inst_i;
  logic        zero_i, mem_ready_i;
  logic        mem_req_o, iord_o, wmem_o, ir_we_o, pc_we_o;
  logic [1:0]  pcsource_o;
  logic        wreg_o, m2reg_o, link_o, aluimm_o;
  logic [3:0]  aluc_o;
  logic        illegal_o;
  logic [2:0]  state_o;

  always #5 clk_i = ~clk_i;

  mc_sequencer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inst_i      (inst_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem_ready_i),
    .mem_req_o   (mem_req_o),
    .iord_o      (iord_o),
    .wmem_o      (wmem_o),
    .ir_we_o     (ir_we_o),
    .pc_we_o     (pc_we_o),
    .pcsource_o  (pcsource_o),
    .wreg_o      (wreg_o),
    .m2reg_o     (m2reg_o),
    .link_o      (link_o),
    .aluimm_o    (aluimm_o),
    .aluc_o      (aluc_o),
    .illegal_o   (illegal_o),
    .state_o     (state_o)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic        chk = 1'b0;
  logic [18:0] exp_v;
  logic [18:0] act_v;

  assign act_v = {mem_req_o, iord_o, wmem_o, ir_we_o, pc_we_o, pcsource_o, wreg_o, m2reg_o,
                  link_o, aluimm_o, aluc_o, illegal_o, state_o};

  // Per-instruction observation logs used by the directed literal checks.
  int          pw_cnt, mem_cnt, st_pack;
  logic [31:0] wr_bits, wm_bits;
  logic [1:0]  pcs_last;
  logic [3:0]  ex_aluc;
  logic        ex_aluimm;

  always @(negedge clk_i) begin
    if (chk) begin
      n_vec++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL outputs t=%0t inst=%h: got %h expected %h", $time, inst_i, act_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic int classify(input logic [31:0] ins);
    case (ins[6:0])
      7'b0110011: return CR;
      7'b0010011: return CI;
      7'b0110111: return CU;
      7'b0000011: return CL;
      7'b0100011: return CS;
      7'b1100011: return (ins[14:12] == 3'b000 || ins[14:12] == 3'b001) ? CB : CX;
      7'b1101111: return CJ;
      7'b1100111: return CJR;
      default:    return CX;
    endcase
  endfunction

  function automatic logic [3:0] ref_aluc(input int c, input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (c == CR) return {ins[30], f3};
    if (c == CI) return {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
    if (c == CB) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [18:0] ref_out(input int ph, input logic [31:0] ins, input logic z,
                                          input logic rdy, input logic rst);
    logic mr, io, wm, ir, pw, wr, m2, lk, ai, il, tk;
    logic [1:0] ps;
    logic [3:0] ac;
    int c;
    c  = classify(ins);
    mr = 0; io = 0; wm = 0; ir = 0; pw = 0; wr = 0; m2 = 0; lk = 0; ai = 0; il = 0;
    ps = 2'b00;
    ac = 4'b0000;
    tk = (ins[14:12] == 3'b000 && z) || (ins[14:12] == 3'b001 && !z);
    case (ph)
      PIF: begin
        mr = 1;
        ir = rdy && !rst;
      end
      PEX: begin
        ai = (c != CR) && (c != CB);
        ac = ref_aluc(c, ins);
        if (c == CB) begin
          pw = 1;
          ps = tk ? 2'b01 : 2'b00;
        end
      end
      PMEM: begin
        mr = 1;
        io = 1;
        wm = (c == CS);
        ac = ref_aluc(c, ins);
        pw = (c == CS) && rdy;
      end
      PWB: begin
        wr = 1;
        pw = 1;
        m2 = (c == CL);
        lk = (c == CJ) || (c == CJR);
        ps = (c == CJ) ? 2'b11 : (c == CJR) ? 2'b10 : 2'b00;
        ac = ref_aluc(c, ins);
      end
      PERR: il = 1;
      default: ;
    endcase
    return {mr, io, wm, ir, pw, ps, wr, m2, lk, ai, ac, il, 3'(ph)};
  endfunction

  task automatic clear_logs();
    pw_cnt = 0; mem_cnt = 0; st_pack = 0; wr_bits = 0; wm_bits = 0;
    pcs_last = 2'b00; ex_aluc = 4'b0000; ex_aluimm = 1'b0;
  endtask

  // One clock cycle: drive inputs at posedge+1, set the model expectation, log, advance.
  task automatic drive_cycle(input int ph, input logic [31:0] ins, input logic z, input logic rdy,
                             input logic rst);
    rst_i = rst; inst_i = ins; zero_i = z; mem_ready_i = rdy;
    exp_v = ref_out(ph, ins, z, rdy, rst);
    chk = 1'b1;
    #1;
    st_pack = (st_pack << 3) | int'(state_o);
    wr_bits = {wr_bits[30:0], wreg_o};
    wm_bits = {wm_bits[30:0], wmem_o};
    pw_cnt += int'(pc_we_o);
    if (pc_we_o) pcs_last = pcsource_o;
    if (state_o == 3'd3) mem_cnt++;
    if (state_o == 3'd2) begin
      ex_aluc = aluc_o;
      ex_aluimm = aluimm_o;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_inst(input logic [31:0] ins, input bit rnd, input int stalls,
                          input logic zv, output int cycles);
    int c, k, st_left, err_cycles;
    int ph[$];
    logic rdy, z;
    c = classify(ins);
    ph.push_back(PIF);
    ph.push_back(PID);
    case (c)
      CL: begin ph.push_back(PEX); ph.push_back(PMEM); ph.push_back(PWB); end
      CS: begin ph.push_back(PEX); ph.push_back(PMEM); end
      CB: ph.push_back(PEX);
      CX: ph.push_back(PERR);
      default: begin ph.push_back(PEX); ph.push_back(PWB); end
    endcase
    clear_logs();
    k = 0; cycles = 0; st_left = stalls; err_cycles = 0;
    while (k < ph.size()) begin
      if (rnd) rdy = ($urandom_range(0, 3) != 0);
      else if (ph[k] == PMEM && st_left > 0) begin rdy = 1'b0; st_left--; end
      else rdy = 1'b1;
      z = rnd ? 1'($urandom_range(0, 1)) : zv;
      drive_cycle(ph[k], ins, z, rdy, 1'b0);
      cycles++;
      if (ph[k] == PERR) begin
        err_cycles++;
        if (err_cycles == 20) k++;
      end else if (!((ph[k] == PIF || ph[k] == PMEM) && !rdy)) begin
        k++;
      end
    end
    if (c == CX) begin
      check("illegal sticky", illegal_o, 1);
      check("ERR pc_we count", pw_cnt, 0);
      for (int i = 0; i < 2; i++) drive_cycle(PIF, ins, 1'b0, 1'b1, 1'b1);
      rst_i = 1'b0;
      check("illegal cleared", illegal_o, 0);
      check("state after reset", state_o, 0);
    end else begin
      check("pc_we once", pw_cnt, 1);
    end
  endtask

  initial begin
    int cyc, sel;
    logic [31:0] ins;
    logic [6:0] opcs [8];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67};
    rst_i = 1'b1; inst_i = 32'h0; zero_i = 1'b0; mem_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) drive_cycle(PIF, 32'h0, 1'b0, 1'b1, 1'b1);
    check("reset state", state_o, 0);
    check("reset mem_req", mem_req_o, 1);
    check("reset ir_we", ir_we_o, 0);

    run_inst(32'h002081B3, 1'b0, 0, 1'b0, cyc);
    check("add cycles", cyc, 4);
    check("add state seq", st_pack, 32'h54);
    check("add wreg WB only", wr_bits, 32'h1);
    check("add aluc", ex_aluc, 0);

    run_inst(32'h0000A183, 1'b0, 2, 1'b0, cyc);
    check("lw stalled cycles", cyc, 7);
    check("lw MEM cycles", mem_cnt, 3);

    run_inst(32'h00208463, 1'b0, 0, 1'b1, cyc);
    check("beq taken cycles", cyc, 3);
    check("beq taken pcsource", pcs_last, 2'b01);
    check("beq taken wreg", wr_bits, 0);
    run_inst(32'h00208463, 1'b0, 0, 1'b0, cyc);
    check("beq not-taken cycles", cyc, 3);
    check("beq not-taken pcsource", pcs_last, 2'b00);

    run_inst(32'h0020A023, 1'b0, 0, 1'b0, cyc);
    check("sw cycles", cyc, 4);
    check("sw state seq", st_pack, 32'h53);
    check("sw wmem in MEM", wm_bits, 32'h1);
    check("sw no wreg", wr_bits, 0);
    run_inst(32'h4020D193, 1'b0, 0, 1'b0, cyc);
    check("srai aluc", ex_aluc, 4'hD);
    check("srai aluimm", ex_aluimm, 1);

    run_inst(32'hFFFFFFFF, 1'b0, 0, 1'b0, cyc);
    check("illegal cycles", cyc, 22);

    // Reset in the middle of a store's memory wait.
    clear_logs();
    drive_cycle(PIF, 32'h0020A023, 1'b0, 1'b1, 1'b0);
    drive_cycle(PID, 32'h0020A023, 1'b0, 1'b1, 1'b0);
    drive_cycle(PEX, 32'h0020A023, 1'b0, 1'b1, 1'b0);
    drive_cycle(PMEM, 32'h0020A023, 1'b0, 1'b0, 1'b0);
    drive_cycle(PMEM, 32'h0020A023, 1'b0, 1'b0, 1'b0);
    rst_i = 1'b1;
    #1;
    check("rst mid-MEM state", state_o, 0);
    check("rst mid-MEM wmem", wmem_o, 0);
    drive_cycle(PIF, 32'h0020A023, 1'b0, 1'b1, 1'b1);
    drive_cycle(PIF, 32'h0020A023, 1'b0, 1'b1, 1'b1);

    for (int n = 0; n < 250; n++) begin
      ins = $urandom;
      sel = $urandom_range(0, 8);
      if (sel < 8) ins[6:0] = opcs[sel];
      if (sel == 5 && $urandom_range(0, 3) != 0) ins[14:13] = 2'b00;
      run_inst(ins, 1'b1, 0, 1'b0, cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
